// File: rtl/game_ctrl.sv
// ----------------------------------------------------------------------------
// game_ctrl -- top-level game state machine for a dodge-the-obstacles game.
//
// Tracks IDLE / PLAY / HIT / OVER, counts surviving frames as score, spends a
// life on each frame that contained a player/obstacle pixel overlap, and
// blinks the player sprite during the post-hit invulnerability window.
//
// Parameters:
//   LIVES      starting lives (1-3)
//   HIT_FRAMES invulnerability length in frames (1-255)
//   SCORE_W    score width in bits
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_pix_stb      pixel strobe
//   i_animate      end-of-visible-frame pulse
//   i_start        start button level
//   i_player_px    current pixel lies inside the player ship
//   i_obstacle_px  current pixel lies inside an obstacle
//   i_pause        pause button level (only with GAME_CTRL_PAUSE_EN)
//   o_state        0=IDLE 1=PLAY 2=HIT 3=OVER
//   o_run          animation enable
//   o_obj_rst      one-cycle object-position reinitialise pulse
//   o_score        frames survived (saturating)
//   o_lives        remaining lives
//   o_show_player  player sprite visibility
//
// Optional feature: define GAME_CTRL_PAUSE_EN to add i_pause and the pause
// logic. All outputs come straight from flops.
// ----------------------------------------------------------------------------
module game_ctrl #(
    parameter int unsigned LIVES      = 3,
    parameter int unsigned HIT_FRAMES = 60,
    parameter int unsigned SCORE_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_stb,
    input  logic               i_animate,
    input  logic               i_start,
    input  logic               i_player_px,
    input  logic               i_obstacle_px,
`ifdef GAME_CTRL_PAUSE_EN
    input  logic               i_pause,
`endif
    output logic [1:0]         o_state,
    output logic               o_run,
    output logic               o_obj_rst,
    output logic [SCORE_W-1:0] o_score,
    output logic [1:0]         o_lives,
    output logic               o_show_player
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPlay = 2'd1;
    localparam logic [1:0] StHit  = 2'd2;
    localparam logic [1:0] StOver = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic               flag_q, flag_d;
    logic [7:0]         timer_q, timer_d;
    logic [3:0]         frame_q, frame_d;
    logic               start_q;
    logic               run_q, run_d;
    logic               obj_rst_q, obj_rst_d;
    logic               show_q, show_d;

    logic               start_edge;
    logic               collide;
    logic               frame_tick;
    logic               in_game_d;
    logic [SCORE_W-1:0] score_inc;
    logic [1:0]         lives_dec;
    logic               paused;       // pause flag as currently held
    logic               paused_next;  // pause flag after this cycle

    assign start_edge = i_start & ~start_q;
    assign collide    = i_pix_stb & i_player_px & i_obstacle_px;
    assign frame_tick = i_animate & ~paused;
    assign score_inc  = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);
    assign lives_dec  = lives_q - 2'd1;

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        lives_d   = lives_q;
        flag_d    = flag_q;
        timer_d   = timer_q;
        frame_d   = frame_q;
        obj_rst_d = 1'b0;

        if (frame_tick) begin
            frame_d = frame_q + 4'd1;
        end

        unique case (state_q)
            StIdle, StOver: begin
                // A start edge swallows a coincident animate pulse entirely.
                if (start_edge) begin
                    state_d   = StPlay;
                    score_d   = '0;
                    lives_d   = 2'(LIVES);
                    flag_d    = 1'b0;
                    timer_d   = '0;
                    frame_d   = frame_q;
                    obj_rst_d = 1'b1;
                end
            end
            StPlay: begin
                if (!paused) begin
                    if (frame_tick) begin
                        // A collision pixel in the animate cycle still counts.
                        if (flag_q || collide) begin
                            lives_d = lives_dec;
                            flag_d  = 1'b0;
                            if (lives_dec == 2'd0) begin
                                state_d = StOver;
                            end else begin
                                state_d = StHit;
                                timer_d = 8'(HIT_FRAMES);
                            end
                        end else begin
                            score_d = score_inc;
                        end
                    end else begin
                        flag_d = flag_q | collide;
                    end
                end
            end
            StHit: begin
                flag_d = 1'b0;
                if (frame_tick) begin
                    timer_d = timer_q - 8'd1;
                    score_d = score_inc;
                    if (timer_q == 8'd1) begin
                        state_d = StPlay;
                    end
                end
            end
        endcase
    end

    assign in_game_d = (state_d == StPlay) || (state_d == StHit);

    always_comb begin
        run_d  = in_game_d & ~paused_next;
        show_d = (state_d == StHit) ? frame_d[3] : 1'b1;
    end

`ifdef GAME_CTRL_PAUSE_EN
    logic pause_q;
    logic paused_q, paused_d;

    always_comb begin
        paused_d = paused_q;
        if ((state_q == StPlay || state_q == StHit) && i_pause && !pause_q) begin
            paused_d = ~paused_q;
        end
        if (!in_game_d) begin
            paused_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pause_q  <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            pause_q  <= i_pause;
            paused_q <= paused_d;
        end
    end

    assign paused      = paused_q;
    assign paused_next = paused_d;
`else
    assign paused      = 1'b0;
    assign paused_next = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            score_q   <= '0;
            lives_q   <= 2'(LIVES);
            flag_q    <= 1'b0;
            timer_q   <= '0;
            frame_q   <= '0;
            start_q   <= 1'b0;
            run_q     <= 1'b0;
            obj_rst_q <= 1'b0;
            show_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            flag_q    <= flag_d;
            timer_q   <= timer_d;
            frame_q   <= frame_d;
            start_q   <= i_start;
            run_q     <= run_d;
            obj_rst_q <= obj_rst_d;
            show_q    <= show_d;
        end
    end

    assign o_state       = state_q;
    assign o_run         = run_q;
    assign o_obj_rst     = obj_rst_q;
    assign o_score       = score_q;
    assign o_lives       = lives_q;
    assign o_show_player = show_q;

endmodule
